// File: rtl/adc_capture_pkg.sv
// Shared types and helpers for the ADC capture bank.
// Averaging is compiled in with ADC_CAPTURE_AVG_EN; see adc_capture_ch.
package adc_capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } snap_state_t;

  // Watchdog counter width; a disabled watchdog (0) still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int unsigned DEFAULT_CNT_W = cnt_width(2000);

endpackage

// File: rtl/adc_capture_ch.sv
// One ADC channel: live (optionally boxcar-averaged) register, stale watchdog.
// Averaging is compiled in with ADC_CAPTURE_AVG_EN.
module adc_capture_ch
  import adc_capture_pkg::*;
#(
  parameter int unsigned DW       = 32,
  parameter int unsigned TIMEOUT  = 2000,
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] tdata,
  input  logic          tvalid,
  input  logic          stale_clr,
  output logic [DW-1:0] live,
  output logic          live_valid,
  output logic          stale
);

`ifdef ADC_CAPTURE_AVG_EN
  localparam int unsigned AW = DW + AVG_LOG2;

  logic signed [AW-1:0]       acc;
  logic signed [AW-1:0]       sum;
  logic        [AVG_LOG2-1:0] fill;

  always_comb begin
    sum = acc + {{AVG_LOG2{tdata[DW-1]}}, tdata};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      fill       <= '0;
      live       <= '0;
      live_valid <= 1'b0;
    end else begin
      live_valid <= 1'b0;
      if (tvalid) begin
        fill <= fill + AVG_LOG2'(1);
        if (&fill) begin
          live       <= DW'(sum >>> AVG_LOG2);
          live_valid <= 1'b1;
          acc        <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live       <= '0;
      live_valid <= 1'b0;
    end else begin
      live_valid <= tvalid;
      if (tvalid) live <= tdata;
    end
  end
`endif

  if (TIMEOUT == 0) begin : g_no_wd
    assign stale = 1'b0;
  end else begin : g_wd
    localparam int unsigned      CW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]    TO = CW'(TIMEOUT);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
      cnt_nxt = cnt;
      if (tvalid)         cnt_nxt = '0;
      else if (cnt != TO) cnt_nxt = cnt + CW'(1);
    end

    // Setting wins over clearing, so a channel still stalled stays flagged.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt   <= '0;
        stale <= 1'b0;
      end else begin
        cnt <= cnt_nxt;
        if (cnt_nxt == TO)  stale <= 1'b1;
        else if (stale_clr) stale <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_capture_bank.sv
// Multi-channel ADC capture bank: per-channel live registers plus a coherent
// request/acknowledge snapshot. Averaging is compiled in with ADC_CAPTURE_AVG_EN.
module adc_capture_bank
  import adc_capture_pkg::*;
#(
  parameter int unsigned NCH      = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned TIMEOUT  = 2000,
  parameter int unsigned AVG_LOG2 = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH*DW-1:0] i_adc_tdata,
  input  logic [NCH-1:0]    i_adc_tvalid,
  output logic [NCH*DW-1:0] o_live,
  output logic [NCH-1:0]    o_live_valid,
  input  logic              i_snap_req,
  output logic              o_snap_ack,
  output logic [NCH*DW-1:0] o_snap,
  output logic [NCH-1:0]    o_stale,
  input  logic              i_stale_clr
);

  if (AVG_LOG2 == 0 || AVG_LOG2 > 16) begin : g_bad_avg
    $error("adc_capture_bank: AVG_LOG2 must be in 1..16");
  end

  logic [DW-1:0] live_ch       [NCH];
  logic          live_valid_ch [NCH];
  logic          stale_ch      [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    adc_capture_ch #(
      .DW       (DW),
      .TIMEOUT  (TIMEOUT),
      .AVG_LOG2 (AVG_LOG2)
    ) u_ch (
      .clk        (i_clk),
      .rst        (i_rst),
      .tdata      (i_adc_tdata[k*DW +: DW]),
      .tvalid     (i_adc_tvalid[k]),
      .stale_clr  (i_stale_clr),
      .live       (live_ch[k]),
      .live_valid (live_valid_ch[k]),
      .stale      (stale_ch[k])
    );
  end

  always_comb begin
    o_live       = '0;
    o_live_valid = '0;
    o_stale      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      o_live[k*DW +: DW] = live_ch[k];
      o_live_valid[k]    = live_valid_ch[k];
      o_stale[k]         = stale_ch[k];
    end
  end

  snap_state_t state;
  snap_state_t state_nxt;
  logic        capture;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_snap_req)  state_nxt = CAPT;
      CAPT:                     state_nxt = HOLD;
      HOLD:    if (!i_snap_req) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    capture    = (state == CAPT);
    o_snap_ack = (state == HOLD);
  end

  // Copies o_live as registered before the capture edge, so a sample landing
  // on the CAPT cycle is excluded from the snapshot.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)       o_snap <= '0;
    else if (capture) o_snap <= o_live;
  end

endmodule

// File: tb/tb_adc_capture_bank.sv
// Scoreboard bench for adc_capture_bank (pass-through or ADC_CAPTURE_AVG_EN build).
module tb_adc_capture_bank;

  localparam int unsigned NCH      = 10;
  localparam int unsigned DW       = 32;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned AVG_LOG2 = 2;
  localparam int unsigned W        = NCH * DW;
`ifdef ADC_CAPTURE_AVG_EN
  localparam int unsigned WIN = 1 << AVG_LOG2;
`else
  localparam int unsigned WIN = 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   tdata;
  logic [NCH-1:0] tvalid;
  logic [W-1:0]   live;
  logic [NCH-1:0] live_valid;
  logic           snap_req;
  logic           snap_ack;
  logic [W-1:0]   snap;
  logic [NCH-1:0] stale;
  logic           stale_clr;

  always #5 clk = ~clk;

  adc_capture_bank #(
    .NCH      (NCH),
    .DW       (DW),
    .TIMEOUT  (TIMEOUT),
    .AVG_LOG2 (AVG_LOG2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_adc_tdata  (tdata),
    .i_adc_tvalid (tvalid),
    .o_live       (live),
    .o_live_valid (live_valid),
    .i_snap_req   (snap_req),
    .o_snap_ack   (snap_ack),
    .o_snap       (snap),
    .o_stale      (stale),
    .i_stale_clr  (stale_clr)
  );

  typedef struct {
    int unsigned   ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          got_e;
  logic [DW-1:0] live_m [NCH];
  longint        acc_m  [NCH];
  int unsigned   cnt_m  [NCH];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < NCH; k++) v[k*DW +: DW] = live_m[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      live_m[k] = '0;
      acc_m[k]  = 0;
      cnt_m[k]  = 0;
    end
  endtask

  task automatic model_sample(input int k, input logic [DW-1:0] s);
    longint a;
    acc_m[k] += longint'(signed'(s));
    cnt_m[k]++;
    if (cnt_m[k] == WIN) begin
      a         = acc_m[k] >>> $clog2(WIN);
      live_m[k] = a[DW-1:0];
      acc_m[k]  = 0;
      cnt_m[k]  = 0;
      sb.push_back('{ch: k, data: live_m[k]});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NCH-1:0] mask, input logic [W-1:0] data, input bit clr);
    tvalid    = mask;
    tdata     = data;
    stale_clr = clr;
    for (int k = 0; k < NCH; k++)
      if (mask[k]) model_sample(k, data[k*DW +: DW]);
    tick();
    tvalid    = '0;
    stale_clr = 1'b0;
  endtask

  function automatic logic [W-1:0] one_ch(input int k, input logic [DW-1:0] v);
    logic [W-1:0] d;
    d = '0;
    d[k*DW +: DW] = v;
    return d;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (live_valid[k]) begin
        if (sb.size() == 0) begin
          check("sb_spurious_ch", W'(k), W'(NCH));
        end else begin
          got_e = sb.pop_front();
          check("sb_ch", W'(k), W'(got_e.ch));
          check("sb_data", W'(live[k*DW +: DW]), W'(got_e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  logic [W-1:0] all_data;
  logic [W-1:0] snap_exp;

  initial begin
    rst       = 1'b0;
    tdata     = '0;
    tvalid    = '0;
    snap_req  = 1'b0;
    stale_clr = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_live", live, '0);
    check("rst_live_valid", W'(live_valid), '0);
    check("rst_snap", snap, '0);
    check("rst_ack", W'(snap_ack), '0);
    check("rst_stale", W'(stale), '0);
    rst = 1'b1;
    tick();

    // Pass-through on one channel; others untouched.
    drive(NCH'(1) << 3, one_ch(3, 32'hDEAD_BEEF), 1'b0);
    check("pt_live3", W'(live[3*DW +: DW]), W'(live_m[3]));
    check("pt_vec", live, model_vec());

    // Snapshot coherence with a sample landing on the CAPT cycle.
    all_data = '0;
    for (int k = 0; k < NCH; k++) all_data[k*DW +: DW] = DW'(k + 1);
    for (int r = 0; r < WIN; r++) drive('1, all_data, 1'b0);
    snap_exp = model_vec();
    snap_req = 1'b1;
    tick();
    check("snap_ack_capt", W'(snap_ack), '0);
    drive(NCH'(1), one_ch(0, 32'h55), 1'b0);
    check("snap_ack_hold", W'(snap_ack), W'(1));
    check("snap_vec", snap, snap_exp);
    check("snap_ch0", W'(snap[DW-1:0]), W'(1));
    check("snap_live0", W'(live[DW-1:0]), W'(live_m[0]));
    drive(NCH'(1) << 1, one_ch(1, 32'h77), 1'b0);
    check("snap_frozen", snap, snap_exp);
    check("snap_ack_held", W'(snap_ack), W'(1));
    snap_req = 1'b0;
    #1;
    check("snap_ack_before_edge", W'(snap_ack), W'(1));
    tick();
    check("snap_ack_fall", W'(snap_ack), '0);

    // Watchdog on channel 5.
    repeat (20) tick();
    check("wd_pre", W'(stale[5]), W'(1));
    drive(NCH'(1) << 5, '0, 1'b1);
    check("wd_clr_valid", W'(stale[5]), '0);
    check("wd_other_stalled", W'(stale[6]), W'(1));
    repeat (TIMEOUT - 1) tick();
    check("wd_before_timeout", W'(stale[5]), '0);
    tick();
    check("wd_at_timeout", W'(stale[5]), W'(1));
    drive('0, '0, 1'b1);
    check("wd_clr_stalled", W'(stale[5]), W'(1));
    drive(NCH'(1) << 5, '0, 1'b1);
    check("wd_clr_after_valid", W'(stale[5]), '0);

    // Signed samples on channel 7; averaged build yields -11 >>> 2.
    drive(NCH'(1) << 7, one_ch(7, -32'sd4), 1'b0);
    drive(NCH'(1) << 7, one_ch(7, -32'sd3), 1'b0);
    drive(NCH'(1) << 7, one_ch(7, -32'sd2), 1'b0);
    drive(NCH'(1) << 7, one_ch(7, -32'sd2), 1'b0);
`ifdef ADC_CAPTURE_AVG_EN
    check("avg_live7", W'(live[7*DW +: DW]), W'(32'hFFFF_FFFD));
`else
    check("last_live7", W'(live[7*DW +: DW]), W'(32'hFFFF_FFFE));
`endif
    tick();
    check("avg_valid_cleared", W'(live_valid), '0);

    // Asynchronous reset while holding a snapshot.
    snap_req = 1'b1;
    tick();
    tick();
    check("rst_hold_ack_pre", W'(snap_ack), W'(1));
    #2;
    rst = 1'b0;
    #1;
    check("rst_hold_ack", W'(snap_ack), '0);
    check("rst_hold_snap", snap, '0);
    check("rst_hold_live", live, '0);
    check("rst_hold_stale", W'(stale), '0);
    model_reset();
    check("rst_hold_sb_empty", W'(sb.size()), '0);
    snap_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int r = 0; r < WIN; r++) drive(NCH'(1) << 2, one_ch(2, 32'h1234), 1'b0);
    snap_req = 1'b1;
    tick();
    tick();
    check("post_rst_ack", W'(snap_ack), W'(1));
    check("post_rst_snap", snap, model_vec());
    snap_req = 1'b0;
    tick();
    check("post_rst_ack_fall", W'(snap_ack), '0);

    repeat (2) tick();
    check("sb_drain", W'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_bank.md
# adc_capture_bank

Parametrised multi-channel ADC sample capture bank. It sits between the ADC AXIS streams and the MPS core register and control logic, and replaces the fixed per-signal hold registers. Each channel keeps a live value, with optional boxcar averaging, and a per-channel stale-data watchdog. A request/acknowledge snapshot freezes all channels on one clock edge, so software reads a coherent set of values.

## Interface
Parameters:
- NCH, 10, number of ADC channels
- DW, 32, sample width in bits (two's complement)
- TIMEOUT, 2000, cycles without tvalid before a channel is flagged stale; 0 disables the watchdog
- AVG_LOG2, 3, log2 of the averaging window; used only when averaging is compiled in

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-low
- i_adc_tdata  in  NCH*DW  channel k occupies bits [k*DW +: DW]
- i_adc_tvalid  in  NCH  per-channel sample strobe
- o_live  out  NCH*DW  latest (or averaged) value per channel
- o_live_valid  out  NCH  one-cycle pulse when o_live[k] updates
- i_snap_req  in  1  snapshot request, level
- o_snap_ack  out  1  snapshot held and valid
- o_snap  out  NCH*DW  frozen copy of o_live
- o_stale  out  NCH  sticky per-channel stale flag
- i_stale_clr  in  1  one-cycle pulse; clears stale flags

## Operation
- Reset: all outputs are 0, all counters and accumulators are 0, and the FSM is in IDLE.
- Live path without averaging: when i_adc_tvalid[k] is high, o_live[k] takes tdata[k] on the next edge and o_live_valid[k] pulses on that edge. When tvalid is low, o_live[k] holds.
- Channels are fully independent. Simultaneous tvalid on any set of channels is legal.
- Watchdog: each channel has a counter, wide enough for $clog2(TIMEOUT+1) bits.
  - The counter resets to 0 on tvalid. Otherwise it increments and saturates at TIMEOUT.
  - o_stale[k] sets on the cycle the counter reaches TIMEOUT and stays set (sticky).
  - i_stale_clr clears o_stale[k] only if the channel's counter is below TIMEOUT. A channel that is still stalled stays flagged.
  - If tvalid and i_stale_clr arrive on the same cycle, the counter resets and the flag clears.
- Snapshot FSM:
  - IDLE: when i_snap_req is high, go to CAPT.
  - CAPT: o_snap <= o_live for all channels in one edge, then go to HOLD.
  - HOLD: o_snap_ack = 1 and o_snap is frozen. When i_snap_req goes low, go to IDLE.
  - If i_snap_req drops during CAPT, the FSM still passes through HOLD for one cycle. This is a legal short ack.
- Reset mid-snapshot: the FSM returns to IDLE, and o_snap and o_snap_ack go to 0.

## Timing
- Live latency: 1 cycle from tvalid to o_live and o_live_valid.
- Snapshot:
  - i_snap_req is first high at edge n.
  - The FSM is in CAPT after edge n and copies o_snap at edge n+1.
  - o_snap_ack is high from edge n+1 (registered with the copy).
  - o_snap_ack falls at the edge after i_snap_req is sampled low.
- The snapshot takes o_live as registered before the capture edge. A sample arriving on the capture cycle is not included.
- A new request is accepted no earlier than the cycle after returning to IDLE.
- Stale flag: set exactly TIMEOUT cycles after the last tvalid edge.

## Configuration
- ADC_CAPTURE_AVG_EN defined:
  - Each channel accumulates 2^AVG_LOG2 signed samples in a register of width DW+AVG_LOG2.
  - On the final sample, o_live[k] <= (acc + sample) >>> AVG_LOG2 (arithmetic shift, truncates toward −∞), o_live_valid[k] pulses, and the accumulator clears.
  - Latency is 1 cycle after the window-completing tvalid.
  - The watchdog still counts raw tvalid.
- ADC_CAPTURE_AVG_EN undefined: no accumulators; behaviour is pass-through as above, and AVG_LOG2 is ignored.

## Structure
- Package adc_capture_pkg holds:
  - the snapshot state enum {IDLE, CAPT, HOLD};
  - a localparam helper for counter width.
- Sub-module adc_capture_ch contains one channel's live/average register, watchdog counter and stale flag. It is instantiated NCH times in a generate loop.
- The top level holds the snapshot FSM and the o_snap registers.

## Test plan
- Passthrough (averaging off): drive ch3 tvalid with 0xDEADBEEF → o_live[3] = 0xDEADBEEF and o_live_valid[3] pulses 1 cycle later; all other channels stay 0.
- Snapshot coherence: load ch0..9 with k+1, raise req, and drive ch0 = 0x55 on the CAPT cycle → o_snap[0] = 1, o_live[0] = 0x55, ack high until 1 cycle after req low.
- Watchdog (TIMEOUT=16): stop ch5 tvalid → o_stale[5] sets exactly 16 cycles later. i_stale_clr while still stalled → flag stays set. One tvalid plus clr → flag clears.
- Averaging (AVG_EN, AVG_LOG2=2): samples −4, −3, −2, −2 → o_live = −3 (−11>>>2), exactly one valid pulse.
- Async reset asserted during HOLD → o_snap_ack, o_snap, o_live and o_stale are all 0 immediately; after release, a new req completes normally.
